dmem_responder: RTL and testbench

- Data-memory responder serving the pipeline's memory-access stage over a single valid/ready request port.
- Returns read data on a fixed-latency response strobe.
- Absorbs stores into a small in-order write buffer that drains to a single-port word array in idle array cycles.
- Keeps the MEM stage from stalling on back-to-back SW/LW/SM traffic.

---
 rtl/dmem_responder.sv | 156 +++++++++++++++
 tb/tb_dmem_responder.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for the MEM stage.
// Loads return on a fixed-latency strobe; stores go into an in-order write
// buffer that drains into a single-port word array when the array is idle.
// Optional feature macro: DMEM_RAW_FORWARD_EN (store-to-load forwarding
// from the write buffer; when absent, loads wait for the buffer to empty).
module dmem_responder #(
  parameter int ADDR_BITS    = 8,
  parameter int READ_LATENCY = 2,
  parameter int WBUF_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        busy
);

  localparam int PW        = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;
  localparam int CW        = $clog2(WBUF_DEPTH + 1);
  localparam int WAIT_INIT = (READ_LATENCY > 1) ? READ_LATENCY - 2 : 0;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rstate_t;

  rstate_t             state, state_n;
  logic [2:0]          wait_cnt;
  logic [15:0]         mem [2**ADDR_BITS];
  logic [ADDR_BITS-1:0] wb_addr [WBUF_DEPTH];
  logic [15:0]         wb_data [WBUF_DEPTH];
  logic [PW-1:0]       head, tail;
  logic [CW-1:0]       count;
  logic [15:0]         ld_data, last_rdata;

  logic [ADDR_BITS-1:0] addr_w;
  logic                 buf_empty, buf_full, load_ok;
  logic                 load_acc, store_acc, drain;

  // Upper address bits alias onto the same word and are intentionally dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[15:ADDR_BITS];

  assign addr_w    = req_addr[ADDR_BITS-1:0];
  assign buf_empty = (count == '0);
  assign buf_full  = (count == CW'(WBUF_DEPTH));

`ifdef DMEM_RAW_FORWARD_EN
  assign load_ok = (state == R_IDLE);
`else
  // Without forwarding the array must be up to date before a load reads it.
  assign load_ok = (state == R_IDLE) && buf_empty;
`endif

  assign req_ready = !reset && (req_write ? !buf_full : load_ok);
  assign load_acc  = req_valid && req_ready && !req_write;
  assign store_acc = req_valid && req_ready && req_write;
  // The array port is owned by a read from acceptance until its response.
  assign drain     = !reset && !buf_empty && !load_acc && (state == R_IDLE);

  assign rsp_valid = !reset && (state == R_RESP);
  assign rsp_rdata = reset ? 16'h0000 : ((state == R_RESP) ? ld_data : last_rdata);
  assign busy      = !reset && (!buf_empty || (state != R_IDLE) || (req_valid && req_ready));

`ifdef DMEM_RAW_FORWARD_EN
  logic        fwd_hit;
  logic [15:0] fwd_data;

  // Scan oldest to youngest so the youngest matching store wins.
  always_comb begin
    logic [PW-1:0] idx;
    fwd_hit  = 1'b0;
    fwd_data = 16'h0000;
    idx      = head;
    for (int i = 0; i < WBUF_DEPTH; i++) begin
      idx = head + PW'(i);
      if ((CW'(i) < count) && (wb_addr[idx] == addr_w)) begin
        fwd_hit  = 1'b1;
        fwd_data = wb_data[idx];
      end
    end
  end
`endif

  // Read FSM next state.
  always_comb begin
    state_n = state;
    case (state)
      R_IDLE: if (load_acc) state_n = (READ_LATENCY == 1) ? R_RESP : R_WAIT;
      R_WAIT: if (wait_cnt == '0) state_n = R_RESP;
      R_RESP: state_n = R_IDLE;
      default: state_n = R_IDLE;
    endcase
  end

  // Read FSM state register and latency counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= R_IDLE;
      wait_cnt <= '0;
    end else begin
      state <= state_n;
      if (load_acc)
        wait_cnt <= 3'(WAIT_INIT);
      else if ((state == R_WAIT) && (wait_cnt != '0))
        wait_cnt <= wait_cnt - 3'd1;
    end
  end

  // Load data is captured at acceptance; array and buffer are not touched by a drain that cycle.
  always_ff @(posedge clk) begin
    if (load_acc) begin
`ifdef DMEM_RAW_FORWARD_EN
      ld_data <= fwd_hit ? fwd_data : mem[addr_w];
`else
      ld_data <= mem[addr_w];
`endif
    end
  end

  // Drain the oldest buffered store into the array.
  always_ff @(posedge clk) begin
    if (drain)
      mem[wb_addr[head]] <= wb_data[head];
  end

  // Push accepted stores at the buffer tail.
  always_ff @(posedge clk) begin
    if (store_acc) begin
      wb_addr[tail] <= addr_w;
      wb_data[tail] <= req_wdata;
    end
  end

  // Buffer pointers, occupancy and held response data.
  always_ff @(posedge clk) begin
    if (reset) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      last_rdata <= 16'h0000;
    end else begin
      if (store_acc) tail <= tail + PW'(1);
      if (drain)     head <= head + PW'(1);
      case ({store_acc, drain})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (state == R_RESP) last_rdata <= ld_data;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a cycle table on a latency-2 instance,
// plus hand sequences for reset abort and buffer-full on a latency-4 instance.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_valid, a_write, a_ready, a_rv, a_busy;
  logic [15:0] a_addr, a_wdata, a_rdata;
  logic        b_valid, b_write, b_ready, b_rv, b_busy;
  logic [15:0] b_addr, b_wdata, b_rdata;

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  dmem_responder u_dut (
    .clk(clk), .reset(reset),
    .req_valid(a_valid), .req_write(a_write), .req_addr(a_addr), .req_wdata(a_wdata),
    .req_ready(a_ready), .rsp_valid(a_rv), .rsp_rdata(a_rdata), .busy(a_busy)
  );

  dmem_responder #(.READ_LATENCY(4)) u_dut4 (
    .clk(clk), .reset(reset),
    .req_valid(b_valid), .req_write(b_write), .req_addr(b_addr), .req_wdata(b_wdata),
    .req_ready(b_ready), .rsp_valid(b_rv), .rsp_rdata(b_rdata), .busy(b_busy)
  );

  typedef struct {
    logic        v, w;
    logic [15:0] addr, wdata;
    logic        rdy, rv;
    logic [15:0] rdata;
    logic        busy;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic v, input logic w, input logic [15:0] addr,
                     input logic [15:0] wdata, input logic rdy, input logic rv,
                     input logic [15:0] rdata, input logic bz);
    vec_t e;
    e.v = v; e.w = w; e.addr = addr; e.wdata = wdata;
    e.rdy = rdy; e.rv = rv; e.rdata = rdata; e.busy = bz;
    vecs.push_back(e);
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic a_drive(input logic v, input logic w, input logic [15:0] addr, input logic [15:0] d);
    a_valid = v; a_write = w; a_addr = addr; a_wdata = d;
  endtask

  task automatic b_drive(input logic v, input logic w, input logic [15:0] addr, input logic [15:0] d);
    b_valid = v; b_write = w; b_addr = addr; b_wdata = d;
  endtask

  // Latency-4 load: bounded wait for ready, then strobe exactly 4 cycles later.
  task automatic load4(input logic [15:0] addr, input logic [15:0] exp);
    int n = 0;
    @(negedge clk); b_drive(1, 0, addr, 0); #2;
    while (!b_ready && n < 50) begin
      @(negedge clk); #2; n++;
    end
    chk("load4 ready", {15'd0, b_ready}, 16'd1);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk); b_drive(0, 1, 0, 0); #2;
      if (k < 4) chk("load4 early rsp", {15'd0, b_rv}, 16'd0);
      else begin
        chk("load4 rsp_valid", {15'd0, b_rv}, 16'd1);
        chk("load4 rdata", b_rdata, exp);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    a_drive(0, 0, 0, 0);
    b_drive(0, 1, 0, 0);

    // Cycle table for the latency-2 instance.
    add(1,1,16'h0010,16'h1234, 1,0,16'h0000,1);
    add(0,1,16'h0000,16'h0000, 1,0,16'h0000,1);
    add(1,0,16'h0010,16'h0000, 1,0,16'h0000,1);
    add(0,1,16'h0000,16'h0000, 1,0,16'h0000,1);
    add(0,1,16'h0000,16'h0000, 1,1,16'h1234,1);
    add(0,1,16'h0000,16'h0000, 1,0,16'h1234,0);
    add(1,1,16'h0020,16'hBEEF, 1,0,16'h1234,1);
`ifdef DMEM_RAW_FORWARD_EN
    add(1,0,16'h0020,16'h0000, 1,0,16'h1234,1);
    add(0,1,16'h0000,16'h0000, 1,0,16'h1234,1);
    add(0,1,16'h0000,16'h0000, 1,1,16'hBEEF,1);
    add(0,1,16'h0000,16'h0000, 1,0,16'hBEEF,1);
    add(0,1,16'h0000,16'h0000, 1,0,16'hBEEF,0);
    // Two stores to 0x30 held in the buffer behind an outstanding load.
    add(1,0,16'h0010,16'h0000, 1,0,16'hBEEF,1);
    add(1,1,16'h0030,16'h1111, 1,0,16'hBEEF,1);
    add(1,1,16'h0030,16'h2222, 1,1,16'h1234,1);
    add(1,0,16'h0030,16'h0000, 1,0,16'h1234,1);
    add(0,1,16'h0000,16'h0000, 1,0,16'h1234,1);
    add(0,1,16'h0000,16'h0000, 1,1,16'h2222,1);
    add(0,1,16'h0000,16'h0000, 1,0,16'h2222,1);
    add(0,1,16'h0000,16'h0000, 1,0,16'h2222,1);
    add(0,1,16'h0000,16'h0000, 1,0,16'h2222,0);
`else
    add(1,0,16'h0020,16'h0000, 0,0,16'h1234,1);
    add(1,0,16'h0020,16'h0000, 1,0,16'h1234,1);
    add(0,1,16'h0000,16'h0000, 1,0,16'h1234,1);
    add(0,1,16'h0000,16'h0000, 1,1,16'hBEEF,1);
    add(0,1,16'h0000,16'h0000, 1,0,16'hBEEF,0);
    add(1,1,16'h0030,16'h1111, 1,0,16'hBEEF,1);
    add(1,1,16'h0030,16'h2222, 1,0,16'hBEEF,1);
    add(1,0,16'h0030,16'h0000, 0,0,16'hBEEF,1);
    add(1,0,16'h0030,16'h0000, 1,0,16'hBEEF,1);
    add(0,1,16'h0000,16'h0000, 1,0,16'hBEEF,1);
    add(0,1,16'h0000,16'h0000, 1,1,16'h2222,1);
    add(0,1,16'h0000,16'h0000, 1,0,16'h2222,0);
`endif
    // Aliasing: 0x0105 and 0x0005 are the same word.
    add(1,1,16'h0105,16'hA5A5, 1,0,16'h2222,1);
    add(0,1,16'h0000,16'h0000, 1,0,16'h2222,1);
    add(1,0,16'h0005,16'h0000, 1,0,16'h2222,1);
    add(0,1,16'h0000,16'h0000, 1,0,16'h2222,1);
    add(0,1,16'h0000,16'h0000, 1,1,16'hA5A5,1);
    add(0,1,16'h0000,16'h0000, 1,0,16'hA5A5,0);

    // Reset state.
    @(negedge clk); #2;
    chk("reset ready", {15'd0, a_ready}, 16'd0);
    chk("reset rsp_valid", {15'd0, a_rv}, 16'd0);
    chk("reset rdata", a_rdata, 16'h0000);
    chk("reset busy", {15'd0, a_busy}, 16'd0);
    @(negedge clk); reset = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      a_drive(vecs[i].v, vecs[i].w, vecs[i].addr, vecs[i].wdata);
      #2;
      chk($sformatf("v%0d ready", i), {15'd0, a_ready}, {15'd0, vecs[i].rdy});
      chk($sformatf("v%0d rsp_valid", i), {15'd0, a_rv}, {15'd0, vecs[i].rv});
      chk($sformatf("v%0d rdata", i), a_rdata, vecs[i].rdata);
      chk($sformatf("v%0d busy", i), {15'd0, a_busy}, {15'd0, vecs[i].busy});
    end

    // Reset one cycle after a load is accepted: the response never appears.
    @(negedge clk); a_drive(1, 0, 16'h0010, 0); #2;
    chk("abort accept", {15'd0, a_ready}, 16'd1);
    @(negedge clk); reset = 1'b1; a_drive(1, 1, 16'h0050, 16'hDEAD); #2;
    chk("abort ready in reset", {15'd0, a_ready}, 16'd0);
    chk("abort busy in reset", {15'd0, a_busy}, 16'd0);
    @(negedge clk); reset = 1'b0; a_drive(0, 1, 0, 0); #2;
    chk("abort no rsp", {15'd0, a_rv}, 16'd0);
    chk("abort busy", {15'd0, a_busy}, 16'd0);
    chk("abort rdata", a_rdata, 16'h0000);

    // Buffered store dropped by reset leaves the array unchanged.
    @(negedge clk); a_drive(1, 1, 16'h0060, 16'h0600);
    @(negedge clk); a_drive(0, 1, 0, 0);
    @(negedge clk); a_drive(1, 1, 16'h0060, 16'hC0DE); #2;
    chk("drop store ready", {15'd0, a_ready}, 16'd1);
    @(negedge clk); reset = 1'b1; a_drive(0, 1, 0, 0);
    @(negedge clk); reset = 1'b0; #2;
    chk("drop busy", {15'd0, a_busy}, 16'd0);
    @(negedge clk); a_drive(1, 0, 16'h0060, 0); #2;
    chk("drop load ready", {15'd0, a_ready}, 16'd1);
    @(negedge clk); a_drive(0, 1, 0, 0); #2;
    chk("drop early rsp", {15'd0, a_rv}, 16'd0);
    @(negedge clk); #2;
    chk("drop rsp_valid", {15'd0, a_rv}, 16'd1);
    chk("drop rdata", a_rdata, 16'h0600);

    // Fill the latency-4 instance's buffer behind an outstanding load.
    @(negedge clk); b_drive(1, 0, 16'h0040, 0); #2;
    chk("fill load ready", {15'd0, b_ready}, 16'd1);
    @(negedge clk); b_drive(1, 1, 16'h0041, 16'h4001); #2;
    chk("fill s1 ready", {15'd0, b_ready}, 16'd1);
    @(negedge clk); b_drive(1, 1, 16'h0042, 16'h4002); #2;
    chk("fill s2 ready", {15'd0, b_ready}, 16'd1);
    @(negedge clk); b_drive(1, 1, 16'h0043, 16'h4003); #2;
    chk("fill s3 ready", {15'd0, b_ready}, 16'd1);
    chk("fill s3 no rsp", {15'd0, b_rv}, 16'd0);
    @(negedge clk); b_drive(1, 1, 16'h0043, 16'h4004); #2;
    chk("fill s4 ready", {15'd0, b_ready}, 16'd1);
    chk("fill rsp_valid", {15'd0, b_rv}, 16'd1);
    @(negedge clk); b_drive(1, 1, 16'h0045, 16'h4005); #2;
    chk("fill s5 blocked", {15'd0, b_ready}, 16'd0);
    chk("fill busy", {15'd0, b_busy}, 16'd1);
    @(negedge clk); #2;
    chk("fill s5 ready", {15'd0, b_ready}, 16'd1);
    @(negedge clk); b_drive(0, 1, 0, 0);

    load4(16'h0041, 16'h4001);
    load4(16'h0042, 16'h4002);
    load4(16'h0043, 16'h4004);
    load4(16'h0045, 16'h4005);

    @(negedge clk); #2;
    chk("fill idle busy", {15'd0, b_busy}, 16'd0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
